multi_clk_gen: RTL
==================

# multi_clk_gen

Synthesisable, multi-channel successor to the single behavioural clock generator. From one system clock it produces NUM_CH independent divided clocks, each with a run-time programmable period, high time (duty) and start-phase offset. Channel configuration updates are glitch-free, and disable is graceful. It sits beside the system clock source and feeds derived enables/strobes to downstream blocks and benches.

## Interface
- NUM_CH, 4, number of output channels (1..16)
- CNT_W, 16, width of period/high/phase fields and channel counters
- DEF_PERIOD, 2, reset value of every channel's period (≥1)
- DEF_HIGH, 1, reset value of every channel's high time (≤ DEF_PERIOD)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel run enable, sampled on clk
- cfg_wr  in  1  single-cycle config write strobe
- cfg_ch  in  4  target channel index
- cfg_period  in  CNT_W  period in clk cycles
- cfg_high  in  CNT_W  high cycles per period
- cfg_phase  in  CNT_W  start delay relative to a phase-0 channel enabled on the same edge
- cfg_err  out  1  one-cycle pulse: last write rejected
- cfg_pending  out  NUM_CH  shadow config waiting to be applied
- running  out  NUM_CH  channel is in RUN or DRAIN
- clk_out  out  NUM_CH  generated clocks (registered)

## Operation
- Per channel: shadow regs (period, high, phase), active regs, counter cnt, pending bit, FSM IDLE/RUN/DRAIN.
- Config write (cfg_wr=1): rejected with cfg_err=1 next cycle and no state change if cfg_ch ≥ NUM_CH, cfg_period=0, cfg_high>cfg_period, or cfg_phase≥cfg_period. Otherwise writes the shadow, sets pending, and overwrites any earlier pending value.
- Apply: in IDLE, pending shadow is copied to active on the next edge. In RUN/DRAIN, it is copied only at the wrap edge (cnt = period_a−1). The new values take effect from cnt=0, and pending clears.
- IDLE: cnt=0, clk_out=0. If en[ch]=1 is sampled: cnt ← (phase_a=0 ? 0 : period_a−phase_a), clk_out ← (that value < high_a), go to RUN.
- RUN: each edge, cnt ← (cnt=period_a−1 ? 0 : cnt+1) and clk_out ← (next cnt < high_a). If en[ch]=0 is sampled, go to DRAIN and keep counting.
- DRAIN: counts as in RUN. On the wrap edge it goes to IDLE with cnt ← 0 and clk_out ← 0. If en[ch]=1 is sampled before the wrap, it returns to RUN with no phase reload and no discontinuity.
- Phase applies only on IDLE→RUN. A new phase written while running takes effect on the next start.
- high_a=0 gives a constant low output. high_a=period_a gives constant high while running. period_a=1 gives constant (high_a) while running.
- A write in the same cycle as the en rise does not affect that start. The start uses the old active values, and the new values apply at the first wrap.

## Timing
- Reset (async assert, sync-safe deassert): clk_out=0, running=0, cfg_pending=0, cfg_err=0, cnt=0, all FSMs IDLE, active = shadow = {DEF_PERIOD, DEF_HIGH, 0}.
- Enable latency: en sampled at edge k; clk_out reflects the first counter value after edge k; running=1 after edge k.
- Output waveform in steady RUN: exactly period_a cycles per period, high for the first high_a cycles after each wrap. Every transition is registered, with no combinational glitches.
- Channels enabled on the same edge with phase p0, p1: channel 1 rising edges lag channel 0's by (p1−p0) mod period when the periods are equal.
- Disable: clk_out is never truncated mid-high. The last low phase completes, and running falls on the wrap edge.
- cfg_err is a pulse one cycle after the offending cfg_wr. cfg_pending rises one cycle after the write and falls on the apply edge.
- Reset mid-run: outputs go low immediately, and all config returns to defaults.

## Test plan
- Reset then en=1 on ch0 with defaults -> clk_out[0] toggles every cycle (period 2, 50%), running[0]=1 one edge after en.
- Write ch1 {period=10, high=3, phase=0} and ch2 {10, 3, 4}, then raise en[1] and en[2] on the same edge -> each is high 3 of 10 cycles; ch2 rises exactly 4 cycles after ch1 every period.
- While ch1 is running at {10, 3}, write {6, 5} mid-period -> cfg_pending[1]=1 until the wrap, the old period completes intact, then the period is 6 with high 5. No runt pulse.
- Drop en[1] at cnt=1 (output high) -> the high phase completes, then low to cnt=9, then IDLE, running[1]=0 at the wrap edge. Re-raising en during DRAIN keeps counting seamlessly.
- Illegal writes {period=0}, {high=11, period=10}, {phase=10, period=10}, and cfg_ch=NUM_CH -> cfg_err pulses once each, and shadow/pending are unchanged.
- Edge duties: {period=5, high=0} stays low, {5, 5} stays high while running, {1, 1} stays high. Assert rst_n=0 mid-run -> all outputs are 0 immediately and config returns to defaults.

Source files
------------

// File: rtl/multi_clk_gen.sv
// Multi-channel programmable clock divider with per-channel period, high time and start phase.
// Config goes to a shadow set and is applied glitch-free at idle or at the counter wrap.
module multi_clk_gen #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_PERIOD = 2,
  parameter int unsigned DEF_HIGH   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DefHigh   = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] One       = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  logic cfg_bad;
  logic cfg_ok;
  logic cfg_err_q;

  always_comb begin
    cfg_bad = (32'(cfg_ch) >= NUM_CH) || (cfg_period == '0) ||
              (cfg_high > cfg_period) || (cfg_phase >= cfg_period);
  end

  assign cfg_ok  = cfg_wr & ~cfg_bad;
  assign cfg_err = cfg_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_wr & cfg_bad;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] per_s_q, high_s_q, ph_s_q;
    logic [CNT_W-1:0] per_a_q, per_a_d;
    logic [CNT_W-1:0] high_a_q, high_a_d;
    logic [CNT_W-1:0] ph_a_q, ph_a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             wr_hit;
    logic             wrap;

    assign wr_hit = cfg_ok && (cfg_ch == 4'(g));
    assign wrap   = (cnt_q == per_a_q - One);

    // Shadow set only ever changes on an accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        per_s_q  <= DefPeriod;
        high_s_q <= DefHigh;
        ph_s_q   <= '0;
      end else if (wr_hit) begin
        per_s_q  <= cfg_period;
        high_s_q <= cfg_high;
        ph_s_q   <= cfg_phase;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= StIdle;
        per_a_q  <= DefPeriod;
        high_a_q <= DefHigh;
        ph_a_q   <= '0;
        cnt_q    <= '0;
        pend_q   <= 1'b0;
        out_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        per_a_q  <= per_a_d;
        high_a_q <= high_a_d;
        ph_a_q   <= ph_a_d;
        cnt_q    <= cnt_d;
        pend_q   <= pend_d;
        out_q    <= out_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      per_a_d  = per_a_q;
      high_a_d = high_a_q;
      ph_a_d   = ph_a_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      pend_d   = pend_q | wr_hit;

      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          out_d = 1'b0;
          // A write landing on this same edge stays pending for later.
          if (pend_q) begin
            per_a_d  = per_s_q;
            high_a_d = high_s_q;
            ph_a_d   = ph_s_q;
            pend_d   = wr_hit;
          end
          if (en[g]) begin
            cnt_d   = (ph_a_d == '0) ? '0 : per_a_d - ph_a_d;
            out_d   = (cnt_d < high_a_d);
            state_d = StRun;
          end
        end

        StRun, StDrain: begin
          if (wrap) begin
            cnt_d = '0;
            if (pend_q) begin
              per_a_d  = per_s_q;
              high_a_d = high_s_q;
              ph_a_d   = ph_s_q;
              pend_d   = wr_hit;
            end
          end else begin
            cnt_d = cnt_q + One;
          end
          out_d = (cnt_d < high_a_d);

          if (state_q == StRun) begin
            if (!en[g]) state_d = StDrain;
          end else if (en[g]) begin
            state_d = StRun;
          end else if (wrap) begin
            state_d = StIdle;
            cnt_d   = '0;
            out_d   = 1'b0;
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      endcase
    end

    assign cfg_pending[g] = pend_q;
    assign running[g]     = (state_q != StIdle);
    assign clk_out[g]     = out_q;
  end

endmodule
